// File: rtl/mem_req_arbiter.sv
// Arbitrates one sram-like master port between the fetch and data requesters.
// Data has fixed priority, one transaction in flight; a cancelled fetch completes silently.
module mem_req_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              inst_cancel,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              owner;        // 1 = data requester, 0 = fetch
    logic              cancel_pend;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic grant_data;
    logic grant_inst;
    logic cancel_hit;
    logic resp_done;

    assign grant_data = (state == IDLE) && data_req;
    assign grant_inst = (state == IDLE) && !data_req && inst_req;
    // A cancel takes effect in the very cycle it arrives, not only from the next one.
    assign cancel_hit = (state != IDLE) && !owner && (cancel_pend || inst_cancel);
    assign resp_done  = m_data_ok && ((state == WAIT) || ((state == ADDR) && m_addr_ok));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_data || grant_inst) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (m_addr_ok && m_data_ok) begin
                    state_next = IDLE;
                end else if (m_addr_ok) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (m_data_ok) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner       <= 1'b0;
            cancel_pend <= 1'b0;
        end else begin
            if (grant_data) begin
                owner <= 1'b1;
            end else if (grant_inst) begin
                owner <= 1'b0;
            end
            if ((state == IDLE) || resp_done) begin
                cancel_pend <= 1'b0;
            end else if (cancel_hit) begin
                cancel_pend <= 1'b1;
            end
        end
    end

    // Request fields are only consumed in ADDR, so they carry no reset.
    always_ff @(posedge clk) begin
        if (grant_data) begin
            wr_q    <= data_wr;
            size_q  <= data_size;
            addr_q  <= data_addr;
            wdata_q <= data_wdata;
        end else if (grant_inst) begin
            wr_q    <= 1'b0;
            size_q  <= 2'd2;
            addr_q  <= inst_addr;
            wdata_q <= '0;
        end
    end

    always_comb begin
        m_req        = 1'b0;
        m_wr         = 1'b0;
        m_size       = 2'd0;
        m_addr       = '0;
        m_wdata      = '0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        case (state)
            ADDR: begin
                m_req        = 1'b1;
                m_wr         = wr_q;
                m_size       = size_q;
                m_addr       = addr_q;
                m_wdata      = wdata_q;
                data_addr_ok = owner && m_addr_ok;
                inst_addr_ok = !owner && m_addr_ok && !cancel_hit;
                data_data_ok = owner && resp_done;
                inst_data_ok = !owner && resp_done && !cancel_hit;
            end
            WAIT: begin
                data_data_ok = owner && resp_done;
                inst_data_ok = !owner && resp_done && !cancel_hit;
            end
            default: begin
            end
        endcase
    end

    assign inst_rdata = inst_data_ok ? m_rdata : '0;
    assign data_rdata = data_data_ok ? m_rdata : '0;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction-level reference of the arbitration rules.
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        inst_cancel;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: the transaction currently owning the port, if any.
    bit        have_txn;
    bit        t_data;
    bit        t_wr;
    bit [1:0]  t_size;
    bit [31:0] t_addr;
    bit [31:0] t_wdata;
    bit        t_acc;
    bit        t_cxl;

    mem_req_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called with inputs already driven after a negedge; checks, updates the
    // reference, then advances to the next negedge.
    task automatic cycle();
        bit e_mreq, cxl, fin, e_iao, e_ido, e_dao, e_ddo;
        #1;
        if (rst) begin
            have_txn = 1'b0;
            t_cxl    = 1'b0;
        end else begin
            e_mreq = have_txn && !t_acc;
            cxl    = have_txn && !t_data && (t_cxl || inst_cancel);
            fin    = have_txn && (t_acc || m_addr_ok) && m_data_ok;
            e_dao  = e_mreq && t_data && m_addr_ok;
            e_iao  = e_mreq && !t_data && m_addr_ok && !cxl;
            e_ddo  = fin && t_data;
            e_ido  = fin && !t_data && !cxl;
            chk("busy", 32'(busy), 32'(have_txn));
            chk("m_req", 32'(m_req), 32'(e_mreq));
            chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e_iao));
            chk("inst_data_ok", 32'(inst_data_ok), 32'(e_ido));
            chk("data_addr_ok", 32'(data_addr_ok), 32'(e_dao));
            chk("data_data_ok", 32'(data_data_ok), 32'(e_ddo));
            if (e_mreq) begin
                chk("m_addr", m_addr, t_addr);
                chk("m_wr", 32'(m_wr), 32'(t_wr));
                chk("m_size", 32'(m_size), 32'(t_size));
                if (t_data) chk("m_wdata", m_wdata, t_wdata);
            end
            if (e_ddo) chk("data_rdata", data_rdata, m_rdata);
            if (e_ido) chk("inst_rdata", inst_rdata, m_rdata);
            if (!have_txn) begin
                if (data_req || inst_req) begin
                    have_txn = 1'b1;
                    t_acc    = 1'b0;
                    t_cxl    = 1'b0;
                    t_data   = data_req;
                    t_wr     = data_req ? data_wr : 1'b0;
                    t_size   = data_req ? data_size : 2'd2;
                    t_addr   = data_req ? data_addr : inst_addr;
                    t_wdata  = data_wdata;
                end
            end else if (fin) begin
                have_txn = 1'b0;
            end else begin
                if (m_addr_ok) t_acc = 1'b1;
                t_cxl = cxl;
            end
        end
        @(negedge clk);
    endtask

    bit ia, da, ic;

    initial begin
        rst = 1'b1; inst_req = 0; inst_addr = 0; inst_cancel = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 32'h5555AAAA;
        have_txn = 0; t_data = 0; t_wr = 0; t_size = 0; t_addr = 0; t_wdata = 0;
        t_acc = 0; t_cxl = 0;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_m_req", 32'(m_req), 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_inst_rdata", inst_rdata, 0);
        chk("rst_data_rdata", data_rdata, 0);
        cycle();

        // 1: plain fetch
        inst_req = 1; inst_addr = 32'hBFC00000;
        #1; chk("t1_grant_no_mreq", 32'(m_req), 0);
        cycle();
        #1; chk("t1_mreq", 32'(m_req), 1); chk("t1_maddr", m_addr, 32'hBFC00000);
        m_addr_ok = 1;
        #1; chk("t1_addr_ok", 32'(inst_addr_ok), 1);
        cycle();
        inst_req = 0; m_addr_ok = 0;
        cycle();
        m_data_ok = 1; m_rdata = 32'h3C1D0001;
        #1; chk("t1_data_ok", 32'(inst_data_ok), 1); chk("t1_rdata", inst_rdata, 32'h3C1D0001);
        cycle();
        m_data_ok = 0;
        #1; chk("t1_idle", 32'(busy), 0);
        cycle();

        // 2: simultaneous requests, data wins
        inst_req = 1; inst_addr = 32'hBFC00004;
        data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h80000010; data_wdata = 32'hDEADBEEF;
        cycle();
        #1; chk("t2_maddr", m_addr, 32'h80000010); chk("t2_mwr", 32'(m_wr), 1);
        chk("t2_mwdata", m_wdata, 32'hDEADBEEF);
        m_addr_ok = 1;
        #1; chk("t2_daddr_ok", 32'(data_addr_ok), 1); chk("t2_iaddr_ok", 32'(inst_addr_ok), 0);
        cycle();
        data_req = 0; m_addr_ok = 0; m_data_ok = 1;
        #1; chk("t2_ddata_ok", 32'(data_data_ok), 1);
        cycle();
        m_data_ok = 0;
        cycle();
        #1; chk("t2_inst_addr", m_addr, 32'hBFC00004); chk("t2_inst_size", 32'(m_size), 2);
        chk("t2_inst_wr", 32'(m_wr), 0);
        m_addr_ok = 1;
        cycle();
        inst_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h12345678;
        cycle();
        m_data_ok = 0;
        cycle();

        // 3: cancel while fetch waits for data
        inst_req = 1; inst_addr = 32'hBFC00100;
        cycle();
        m_addr_ok = 1;
        cycle();
        inst_req = 0; m_addr_ok = 0; inst_cancel = 1;
        cycle();
        inst_cancel = 0;
        cycle();
        m_data_ok = 1;
        #1; chk("t3_suppressed", 32'(inst_data_ok), 0);
        cycle();
        m_data_ok = 0;
        #1; chk("t3_idle", 32'(busy), 0);
        inst_req = 1; inst_addr = 32'hBFC00200;
        cycle();
        m_addr_ok = 1;
        #1; chk("t3_next_addr_ok", 32'(inst_addr_ok), 1);
        cycle();
        inst_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hCAFEF00D;
        #1; chk("t3_next_data_ok", 32'(inst_data_ok), 1);
        cycle();
        m_data_ok = 0;
        cycle();

        // 4: downstream stalls the address phase
        data_req = 1; data_wr = 1; data_size = 1; data_addr = 32'h80001002; data_wdata = 32'h0000BEEF;
        cycle();
        for (int k = 0; k < 5; k++) begin
            #1; chk("t4_mreq", 32'(m_req), 1); chk("t4_maddr", m_addr, 32'h80001002);
            chk("t4_mwdata", m_wdata, 32'h0000BEEF); chk("t4_no_addr_ok", 32'(data_addr_ok), 0);
            cycle();
        end
        m_addr_ok = 1;
        #1; chk("t4_addr_ok", 32'(data_addr_ok), 1);
        cycle();
        data_req = 0; m_addr_ok = 0; m_data_ok = 1;
        cycle();
        m_data_ok = 0;
        cycle();

        // 5: address and data accepted together
        inst_req = 1; inst_addr = 32'hBFC00300;
        cycle();
        m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h0BADCAFE;
        #1; chk("t5_addr_ok", 32'(inst_addr_ok), 1); chk("t5_data_ok", 32'(inst_data_ok), 1);
        cycle();
        inst_req = 0; m_addr_ok = 0; m_data_ok = 0;
        #1; chk("t5_idle", 32'(busy), 0);
        cycle();

        // 6: reset during WAIT
        inst_req = 1; inst_addr = 32'hBFC00400;
        cycle();
        m_addr_ok = 1;
        cycle();
        inst_req = 0; m_addr_ok = 0;
        cycle();
        rst = 1;
        cycle();
        rst = 0; m_data_ok = 1;
        #1; chk("t6_busy", 32'(busy), 0); chk("t6_no_ido", 32'(inst_data_ok), 0);
        chk("t6_no_ddo", 32'(data_data_ok), 0);
        cycle();
        m_data_ok = 0;
        cycle();

        // Randomized traffic
        ia = 0; da = 0; ic = 0;
        for (int i = 0; i < 3000; i++) begin
            if (inst_req && (ia || ic)) inst_req = 0;
            else if (!inst_req && $urandom_range(0, 3) == 0) begin
                inst_req  = 1;
                inst_addr = $urandom & 32'hFFFFFFFC;
            end
            if (data_req && da) data_req = 0;
            else if (!data_req && $urandom_range(0, 3) == 0) begin
                data_req   = 1;
                data_wr    = 1'($urandom_range(0, 1));
                data_size  = 2'($urandom_range(0, 2));
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            inst_cancel = ($urandom_range(0, 9) == 0);
            m_addr_ok   = ($urandom_range(0, 2) == 0);
            m_data_ok   = ($urandom_range(0, 2) == 0);
            m_rdata     = $urandom;
            rst         = ($urandom_range(0, 199) == 0);
            if (rst) begin
                m_addr_ok = 0; m_data_ok = 0; inst_req = 0; data_req = 0;
            end
            ic = inst_cancel;
            #1;
            ia = inst_addr_ok;
            da = data_addr_ok;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
